// File: rtl/mul_ctrl_fsm.sv
// Control FSM for a repeated-add multiplier: loads A then B over a shared bus, adds A into P
// until the B counter hits zero, then pulses done. Define MUL_CTRL_TIMEOUT_EN for iteration timeout.
module mul_ctrl_fsm #(
  parameter int MAX_ITER = 65535,
  parameter int ITER_W   = 17
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic abort,
  input  logic op_valid,
  output logic op_ready,
  input  logic eqz,
  output logic lda,
  output logic ldb,
  output logic clrp,
  output logic ldp,
  output logic decb,
  output logic busy,
  output logic done,
  output logic err
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LDA  = 3'd1,
    LDB  = 3'd2,
    ACC  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t state, state_nxt;
  logic   timeout;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every output of this block is defaulted first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    op_ready  = 1'b0;
    lda       = 1'b0;
    ldb       = 1'b0;
    clrp      = 1'b0;
    ldp       = 1'b0;
    decb      = 1'b0;
    unique case (state)
      IDLE: if (start) state_nxt = LDA;
      LDA: begin
        op_ready = 1'b1;
        lda      = op_valid;
        if (op_valid) state_nxt = LDB;
      end
      LDB: begin
        op_ready = 1'b1;
        ldb      = op_valid;
        clrp     = op_valid;
        if (op_valid) state_nxt = ACC;
      end
      ACC: begin
        if (eqz || timeout) begin
          state_nxt = DONE;
        end else begin
          ldp  = 1'b1;
          decb = 1'b1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // Abort wins over every other condition, including start in IDLE.
    if (abort) begin
      state_nxt = IDLE;
      op_ready  = 1'b0;
      lda       = 1'b0;
      ldb       = 1'b0;
      clrp      = 1'b0;
      ldp       = 1'b0;
      decb      = 1'b0;
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

`ifdef MUL_CTRL_TIMEOUT_EN
  logic [ITER_W-1:0] iter_cnt;
  logic              to_q;

  // to_q remembers that the coming DONE cycle was reached by timeout rather than eqz.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iter_cnt <= '0;
      to_q     <= 1'b0;
    end else begin
      if (state == LDB && op_valid && !abort) iter_cnt <= '0;
      else if (ldp)                           iter_cnt <= iter_cnt + ITER_W'(1);
      to_q <= (state == ACC) && !eqz && timeout && !abort;
    end
  end

  assign timeout = (iter_cnt == ITER_W'(MAX_ITER));
  assign err     = (state == DONE) && to_q;
`else
  logic unused_cfg;
  assign unused_cfg = (MAX_ITER > 0) && (ITER_W > 0);
  assign timeout    = 1'b0;
  assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_mul_ctrl_fsm.sv
// Directed bench for mul_ctrl_fsm with a small behavioural A/B/P datapath attached.
// Expectations branch on MUL_CTRL_TIMEOUT_EN for the forced-eqz timeout case.
module tb_mul_ctrl_fsm;
  logic clk = 1'b0;
  logic rst_n, start, abort, op_valid, eqz;
  logic op_ready, lda, ldb, clrp, ldp, decb, busy, done, err;
  logic [15:0] data_in, a_reg, b_reg, p_reg;
  logic force_nz;
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mul_ctrl_fsm #(.MAX_ITER(4), .ITER_W(17)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .op_valid(op_valid),
    .op_ready(op_ready), .eqz(eqz), .lda(lda), .ldb(ldb), .clrp(clrp), .ldp(ldp),
    .decb(decb), .busy(busy), .done(done), .err(err)
  );

  // Datapath stand-in: A register, B down-counter, 16-bit accumulator P.
  always @(posedge clk) begin
    if (lda) a_reg <= data_in;
    if (ldb) b_reg <= data_in;
    else if (decb) b_reg <= b_reg - 16'd1;
    if (clrp) p_reg <= 16'd0;
    else if (ldp) p_reg <= p_reg + a_reg;
  end
  assign eqz = force_nz ? 1'b0 : (b_reg == 16'd0);

  wire [8:0] outs = {op_ready, lda, ldb, clrp, ldp, decb, busy, done, err};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Counts ACC cycles from the cycle after B accept until done or budget expiry (lat = -1).
  task automatic wait_done(input int budget, output int ldps, output int lat, output logic err_at_done);
    ldps = 0; lat = -1; err_at_done = 1'b0;
    for (int k = 0; k < budget; k++) begin
      #1;
      if (done) begin
        lat = k + 1;
        err_at_done = err;
        break;
      end
      if (ldp) ldps++;
      @(negedge clk);
    end
  endtask

  // Starts an operation and hands over A then B; returns at the negedge of the first ACC cycle.
  task automatic load_ops(input logic [15:0] a, input logic [15:0] b);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0; op_valid = 1'b1; data_in = a;
    #1 check("lda_strobe", {op_ready, lda, busy}, 3'b111);
    @(negedge clk) data_in = b;
    #1 check("ldb_strobe", {op_ready, ldb, clrp}, 3'b111);
    @(negedge clk) op_valid = 1'b0;
  endtask

  int ldps, lat;
  logic e_done;

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; op_valid = 1'b0; data_in = '0; force_nz = 1'b0;
    #12 check("reset_outs", outs, 9'd0);
    @(negedge clk) rst_n = 1'b1;
    #1 check("idle_outs", outs, 9'd0);

    // 5*3
    load_ops(16'd5, 16'd3);
    wait_done(50, ldps, lat, e_done);
    check("t1_ldps", ldps, 3);
    check("t1_lat", lat, 5);
    check("t1_p", p_reg, 16'd15);
    check("t1_err", e_done, 1'b0);
    check("t1_busy_done", {busy, done}, 2'b11);
    @(negedge clk) #1 check("t1_idle_after", {busy, done}, 2'b00);

    // B = 0 and A = 0
    load_ops(16'd7, 16'd0);
    wait_done(50, ldps, lat, e_done);
    check("t2a_ldps", ldps, 0);
    check("t2a_lat", lat, 2);
    check("t2a_p", p_reg, 16'd0);
    load_ops(16'd0, 16'd4);
    wait_done(50, ldps, lat, e_done);
    check("t2b_ldps", ldps, 4);
    check("t2b_p", p_reg, 16'd0);

    // op_valid gaps in LDA and LDB
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 check("t3_lda_wait", {op_ready, lda}, 2'b10);
      @(negedge clk);
    end
    op_valid = 1'b1; data_in = 16'd6;
    #1 check("t3_lda_go", {op_ready, lda}, 2'b11);
    @(negedge clk) op_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 check("t3_ldb_wait", {op_ready, ldb, clrp}, 3'b100);
      @(negedge clk);
    end
    op_valid = 1'b1; data_in = 16'd2;
    #1 check("t3_ldb_go", {op_ready, ldb, clrp}, 3'b111);
    @(negedge clk) op_valid = 1'b0;
    wait_done(50, ldps, lat, e_done);
    check("t3_lat", lat, 4);
    check("t3_p", p_reg, 16'd12);

    // start ignored in ACC, then abort after adds
    load_ops(16'd3, 16'd10);
    @(negedge clk);
    @(negedge clk) start = 1'b1;
    #1 check("t4_start_in_acc", {busy, ldp, decb}, 3'b111);
    @(negedge clk) start = 1'b0; abort = 1'b1;
    #1 check("t4_abort_outs", outs, 9'b000000100);
    @(negedge clk) abort = 1'b0;
    #1 check("t4_after_abort", outs, 9'd0);
    check("t4_p", p_reg, 16'd9);
    @(negedge clk) start = 1'b1; abort = 1'b1;
    @(negedge clk) start = 1'b0; abort = 1'b0;
    #1 check("t4_start_abort_idle", busy, 1'b0);

    // Reset mid-ACC
    load_ops(16'd3, 16'd10);
    @(negedge clk) rst_n = 1'b0;
    #1 check("t5_reset_async", outs, 9'd0);
    @(negedge clk) rst_n = 1'b1;
    load_ops(16'd4, 16'd4);
    wait_done(50, ldps, lat, e_done);
    check("t5_ldps", ldps, 4);
    check("t5_p", p_reg, 16'd16);

    // eqz forced low: timeout with macro, endless ACC without
    force_nz = 1'b1;
    load_ops(16'd1, 16'd9);
`ifdef MUL_CTRL_TIMEOUT_EN
    wait_done(50, ldps, lat, e_done);
    check("t6_ldps", ldps, 4);
    check("t6_lat", lat, 6);
    check("t6_err", e_done, 1'b1);
    @(negedge clk) #1 check("t6_after", {busy, done, err}, 3'b000);
`else
    wait_done(20, ldps, lat, e_done);
    check("t6_no_done", lat, -1);
    check("t6_ldps", ldps, 20);
    check("t6_err", err, 1'b0);
    abort = 1'b1;
    @(negedge clk) abort = 1'b0;
    #1 check("t6_after", outs, 9'd0);
`endif
    force_nz = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
